// File: rtl/pwm_decoder.sv
// Recovers the duty value of a fixed-period PWM line: measures high cycles per period,
// flags off-nominal periods and reports a static level when the line stops toggling.
module pwm_decoder #(
  parameter int PERIOD  = 256,
  parameter int TOL     = 4,
  parameter int TIMEOUT = 1024,
  parameter int CW      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pwm_in,
  output logic [7:0] control_value,
  output logic       valid,
  output logic       period_error,
  output logic       static_level
);

  typedef enum logic [1:0] {IDLE, MEASURE, STATIC} state_t;

  localparam logic [CW-1:0]          TO_C     = CW'(TIMEOUT);
  localparam logic signed [CW+1:0]   PERIOD_S = (CW+2)'(PERIOD);
  localparam logic signed [CW+1:0]   TOL_S    = (CW+2)'(TOL);

  state_t        state, state_nxt;
  logic          pwm_meta, pwm_s, pwm_d;
  logic          rise, at_timeout;
  logic [CW-1:0] p_cnt, h_cnt;
  logic [7:0]    cv_nxt;
  logic          valid_nxt, err_nxt, static_nxt;

  function automatic logic in_tol(input logic [CW-1:0] p);
    logic signed [CW+1:0] diff;
    diff = $signed({2'b00, p}) - PERIOD_S;
    if (diff < 0) diff = -diff;
    return (diff <= TOL_S);
  endfunction

  function automatic logic [7:0] sat8(input logic [CW-1:0] h);
    return (h > CW'(255)) ? 8'hFF : h[7:0];
  endfunction

  assign rise       = pwm_s & ~pwm_d;
  assign at_timeout = (p_cnt == TO_C);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cv_nxt     = control_value;
    valid_nxt  = 1'b0;
    err_nxt    = 1'b0;
    static_nxt = static_level;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = MEASURE;
        end else if (at_timeout) begin
          state_nxt  = STATIC;
          cv_nxt     = pwm_s ? 8'hFF : 8'h00;
          valid_nxt  = 1'b1;
          static_nxt = 1'b1;
        end
      end
      MEASURE: begin
        // A rise coinciding with a saturated counter is always an out-of-tolerance window.
        if (rise) begin
          if (in_tol(p_cnt) && !at_timeout) begin
            cv_nxt    = sat8(h_cnt);
            valid_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end else if (at_timeout) begin
          state_nxt  = STATIC;
          cv_nxt     = pwm_s ? 8'hFF : 8'h00;
          valid_nxt  = 1'b1;
          static_nxt = 1'b1;
        end
      end
      STATIC: begin
        if (rise) begin
          state_nxt  = MEASURE;
          static_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Synchronizer, edge-delay flop, window counters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_meta      <= 1'b0;
      pwm_s         <= 1'b0;
      pwm_d         <= 1'b0;
      p_cnt         <= '0;
      h_cnt         <= '0;
      control_value <= 8'h00;
      valid         <= 1'b0;
      period_error  <= 1'b0;
      static_level  <= 1'b0;
    end else begin
      pwm_meta      <= pwm_in;
      pwm_s         <= pwm_meta;
      pwm_d         <= pwm_s;
      control_value <= cv_nxt;
      valid         <= valid_nxt;
      period_error  <= err_nxt;
      static_level  <= static_nxt;
      // The rise cycle is the first cycle of the new window, and it is always high.
      if (rise) begin
        p_cnt <= CW'(1);
        h_cnt <= CW'(1);
      end else begin
        if (p_cnt != TO_C)          p_cnt <= p_cnt + CW'(1);
        if (pwm_s && h_cnt != TO_C) h_cnt <= h_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pwm_decoder.sv
// Directed bench for pwm_decoder: table of PWM waveforms plus hand-written
// sequences for latency, duty switching, static detection and mid-window reset.
module tb_pwm_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pwm_in = 1'b0;
  logic [7:0] control_value;
  logic       valid, period_error, static_level;

  pwm_decoder #(.PERIOD(256), .TOL(4), .TIMEOUT(1024), .CW(16)) dut (
    .clk(clk), .reset(reset), .pwm_in(pwm_in),
    .control_value(control_value), .valid(valid),
    .period_error(period_error), .static_level(static_level)
  );

  always #5 clk = ~clk;

  int cycn = 0;
  always @(posedge clk) cycn <= cycn + 1;

  // Output monitor: logs every valid pulse (value and cycle) and counts error pulses
  int vals[$];
  int vtimes[$];
  int ecount = 0;
  int both = 0;
  always @(negedge clk) begin
    if (valid) begin
      vals.push_back(int'(control_value));
      vtimes.push_back(cycn);
    end
    if (period_error) ecount++;
    if (valid && period_error) both++;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input int n);
    pwm_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    pwm_in = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  typedef struct {
    int high;
    int period;
    int nper;
    int exp_valid;
    int exp_err;
    int exp_cv;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int bv, be, bad;

    vecs[0] = '{100, 256, 3, 3, 0, 100};
    vecs[1] = '{200, 256, 2, 2, 0, 200};
    vecs[2] = '{255, 256, 2, 2, 0, 255};
    vecs[3] = '{259, 260, 2, 2, 0, 255};
    vecs[4] = '{ 10, 260, 2, 2, 0,  10};
    vecs[5] = '{ 10, 261, 2, 0, 2,   0};
    vecs[6] = '{  1, 252, 2, 2, 0,   1};
    vecs[7] = '{  1, 251, 2, 0, 2,   0};
    vecs[8] = '{100, 300, 3, 0, 3,   0};

    // Reset state
    #2 reset = 1'b0;
    #1;
    check("rst_cv", control_value, 0);
    check("rst_valid", valid, 0);
    check("rst_err", period_error, 0);
    check("rst_static", static_level, 0);
    do_reset();

    // Table-driven waveforms, each from a fresh reset
    for (int i = 0; i < 9; i++) begin
      do_reset();
      bv = vals.size();
      be = ecount;
      for (int k = 0; k < vecs[i].nper; k++) begin
        cyc(1'b1, vecs[i].high);
        cyc(1'b0, vecs[i].period - vecs[i].high);
      end
      cyc(1'b1, 4);
      check($sformatf("vec%0d_valid_cnt", i), vals.size() - bv, vecs[i].exp_valid);
      check($sformatf("vec%0d_err_cnt", i), ecount - be, vecs[i].exp_err);
      check($sformatf("vec%0d_cv", i), control_value, vecs[i].exp_cv);
      if (vecs[i].exp_valid > 0)
        check($sformatf("vec%0d_last_val", i), vals[vals.size()-1], vecs[i].exp_cv);
      if (vecs[i].exp_valid >= 2) begin
        bad = 0;
        for (int k = bv + 1; k < vals.size(); k++)
          if (vtimes[k] - vtimes[k-1] != vecs[i].period) bad++;
        check($sformatf("vec%0d_interval", i), bad, 0);
      end
    end

    // Latency: valid on the 3rd edge after the rise is first sampled
    do_reset();
    cyc(1'b1, 100);
    cyc(1'b0, 156);
    pwm_in = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("lat_edge2_valid", valid, 0);
    @(negedge clk);
    check("lat_edge3_valid", valid, 1);
    check("lat_edge3_cv", control_value, 100);

    // Duty switch 100 -> 200 mid-window
    do_reset();
    bv = vals.size();
    cyc(1'b1, 100); cyc(1'b0, 156);
    cyc(1'b1, 100); cyc(1'b0, 156);
    cyc(1'b1, 200); cyc(1'b0, 56);
    cyc(1'b1, 4);
    check("switch_cnt", vals.size() - bv, 3);
    if (vals.size() - bv == 3) begin
      check("switch_v0", vals[bv], 100);
      check("switch_v1", vals[bv+1], 100);
      check("switch_v2", vals[bv+2], 200);
    end

    // Static low after a valid window, then resume at duty 50
    do_reset();
    bv = vals.size();
    cyc(1'b1, 100); cyc(1'b0, 156);
    cyc(1'b1, 100); cyc(1'b0, 1100);
    check("slow_cnt", vals.size() - bv, 2);
    check("slow_static", static_level, 1);
    check("slow_cv", control_value, 0);
    if (vals.size() - bv == 2) begin
      check("slow_v0", vals[bv], 100);
      check("slow_v1", vals[bv+1], 0);
      check("slow_delay", vtimes[bv+1] - vtimes[bv], 1024);
    end
    pwm_in = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("slow_exit_edge2", static_level, 1);
    @(negedge clk);
    check("slow_exit_edge3", static_level, 0);
    @(posedge clk); #1;
    cyc(1'b1, 46);
    cyc(1'b0, 206);
    check("slow_partial_cnt", vals.size() - bv, 2);
    cyc(1'b1, 4);
    check("slow_resume_cnt", vals.size() - bv, 3);
    check("slow_resume_cv", control_value, 50);
    check("slow_resume_static", static_level, 0);

    // Static high from reset
    do_reset();
    bv = vals.size();
    cyc(1'b1, 1100);
    check("shigh_cnt", vals.size() - bv, 1);
    check("shigh_cv", control_value, 255);
    check("shigh_static", static_level, 1);

    // Period 300 after a good window: errors only, value holds
    do_reset();
    bv = vals.size();
    be = ecount;
    cyc(1'b1, 100); cyc(1'b0, 156);
    cyc(1'b1, 100); cyc(1'b0, 156);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 100);
      cyc(1'b0, 200);
    end
    cyc(1'b1, 4);
    check("p300_valid_cnt", vals.size() - bv, 2);
    check("p300_err_cnt", ecount - be, 3);
    check("p300_cv_hold", control_value, 100);

    // Asynchronous reset mid-window
    do_reset();
    cyc(1'b1, 100); cyc(1'b0, 156);
    cyc(1'b1, 100); cyc(1'b0, 50);
    check("mid_pre_cv", control_value, 100);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_cv", control_value, 0);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_static", static_level, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    bv = vals.size();
    cyc(1'b0, 100);
    cyc(1'b1, 100); cyc(1'b0, 156);
    check("mid_first_rise_cnt", vals.size() - bv, 0);
    cyc(1'b1, 4);
    check("mid_second_rise_cnt", vals.size() - bv, 1);
    check("mid_second_rise_cv", control_value, 100);

    check("valid_err_overlap", both, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
